rx_word_packer: RTL and testbench

- Receive-side front end of the MAC: takes the PHY byte stream (8-bit data, data-valid, error) and removes the preamble/SFD.
- Packs frame bytes big-endian into 16-bit words and numbers each word from 1.
- Produces the word/number/valid/done bus consumed directly by the destination-address check stage (MAC address in words 1..3).
- Also reports frame length and receive errors to the RX control logic.

---
 rtl/rx_word_packer.sv | 187 ++++++++++++++++++
 tb/tb_rx_word_packer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_word_packer.sv
// Receive front end: strips preamble/SFD from the PHY byte stream and packs frame
// bytes big-endian into numbered 16-bit words. Optional CRC-32 check: RX_FCS_CHECK_EN.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for the first 0x55 of a preamble
// S_PREAMBLE | counting 0x55 bytes, waiting for SFD 0xD5
// S_DATA     | frame payload: pairing bytes into words
// S_FLUSH    | padded odd tail word emitted, end-of-frame strobe next
// S_DROP     | bad preamble, ignore bytes until dv falls
module rx_word_packer #(
    parameter int MAX_WORDS    = 760,
    parameter int MIN_PREAMBLE = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_rxd,
    input  logic        i_rx_dv,
    input  logic        i_rx_er,
    output logic [15:0] o_rx_data,
    output logic [9:0]  o_wordNum,
    output logic        o_data_valid,
    output logic        o_recvDn,
    output logic [10:0] o_byte_len,
    output logic        o_rx_err,
    output logic        o_fcs_err
);

    localparam logic [9:0] MAX_W   = 10'(MAX_WORDS);
    localparam logic [3:0] MIN_PRE = 4'(MIN_PREAMBLE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_DATA,
        S_FLUSH,
        S_DROP
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  pre_cnt;
    logic        phase_hi;
    logic [7:0]  hi_byte;
    logic        start_frame;
    logic        end_frame;
    logic        word_room;
    logic        fcs_bad;

    assign word_room = (o_wordNum < MAX_W);

`ifdef RX_FCS_CHECK_EN
    logic [31:0] crc;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[31] ^ d[i];
            r  = {r[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
        end
        return r;
    endfunction

    assign fcs_bad = (o_byte_len < 11'd4) || (crc != 32'hC704DD7B);
`else
    assign fcs_bad   = 1'b0;
    assign o_fcs_err = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        start_frame = 1'b0;
        end_frame   = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_rx_dv) state_nxt = (i_rxd == 8'h55) ? S_PREAMBLE : S_DROP;
            end
            S_PREAMBLE: begin
                if (!i_rx_dv) begin
                    state_nxt = S_IDLE;
                end else if (i_rxd == 8'h55) begin
                    state_nxt = S_PREAMBLE;
                end else if (i_rxd == 8'hD5 && pre_cnt >= MIN_PRE) begin
                    state_nxt   = S_DATA;
                    start_frame = 1'b1;
                end else begin
                    state_nxt = S_DROP;
                end
            end
            S_DATA: begin
                if (!i_rx_dv) begin
                    end_frame = 1'b1;
                    state_nxt = (!phase_hi && word_room) ? S_FLUSH : S_IDLE;
                end
            end
            S_FLUSH: state_nxt = S_IDLE;
            S_DROP: begin
                if (!i_rx_dv) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pre_cnt      <= 4'd0;
            phase_hi     <= 1'b1;
            hi_byte      <= 8'h00;
            o_rx_data    <= 16'h0000;
            o_wordNum    <= 10'd0;
            o_data_valid <= 1'b0;
            o_recvDn     <= 1'b0;
            o_byte_len   <= 11'd0;
            o_rx_err     <= 1'b0;
`ifdef RX_FCS_CHECK_EN
            o_fcs_err    <= 1'b0;
            crc          <= 32'hFFFF_FFFF;
`endif
        end else begin
            o_data_valid <= 1'b0;
            o_recvDn     <= 1'b0;

            if (state == S_IDLE) begin
                pre_cnt <= 4'd1;
            end else if (state == S_PREAMBLE && i_rx_dv && i_rxd == 8'h55 && pre_cnt != 4'hF) begin
                pre_cnt <= pre_cnt + 4'd1;
            end

            if (start_frame) begin
                phase_hi   <= 1'b1;
                o_rx_data  <= 16'h0000;
                o_wordNum  <= 10'd0;
                o_byte_len <= 11'd0;
                o_rx_err   <= 1'b0;
`ifdef RX_FCS_CHECK_EN
                o_fcs_err  <= 1'b0;
                crc        <= 32'hFFFF_FFFF;
`endif
            end

            if (state == S_DATA && i_rx_dv) begin
                if (o_byte_len != 11'h7FF) o_byte_len <= o_byte_len + 11'd1;
`ifdef RX_FCS_CHECK_EN
                crc <= crc_step(crc, i_rxd);
`endif
                if (phase_hi) begin
                    hi_byte  <= i_rxd;
                    phase_hi <= 1'b0;
                    if (i_rx_er) o_rx_err <= 1'b1;
                end else begin
                    phase_hi <= 1'b1;
                    if (word_room) begin
                        o_rx_data    <= {hi_byte, i_rxd};
                        o_wordNum    <= o_wordNum + 10'd1;
                        o_data_valid <= 1'b1;
                    end
                    if (i_rx_er || !word_room) o_rx_err <= 1'b1;
                end
            end

            // Odd tail is padded with 0x00; the done strobe waits one cycle behind it.
            if (end_frame) begin
                phase_hi <= 1'b1;
                if (!phase_hi && word_room) begin
                    o_rx_data    <= {hi_byte, 8'h00};
                    o_wordNum    <= o_wordNum + 10'd1;
                    o_data_valid <= 1'b1;
                end else begin
                    o_recvDn <= 1'b1;
                end
                o_rx_err <= o_rx_err | (!phase_hi && !word_room) | fcs_bad;
`ifdef RX_FCS_CHECK_EN
                o_fcs_err <= fcs_bad;
`endif
            end

            if (state == S_FLUSH) o_recvDn <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rx_word_packer.sv
// Scoreboard bench for rx_word_packer: random and directed frames checked against
// a byte-array reference model; honours RX_FCS_CHECK_EN when defined.
module tb_rx_word_packer;

    localparam int MAX_WORDS = 760;

    logic        i_clk;
    logic        i_rst;
    logic [7:0]  i_rxd;
    logic        i_rx_dv;
    logic        i_rx_er;
    logic [15:0] o_rx_data;
    logic [9:0]  o_wordNum;
    logic        o_data_valid;
    logic        o_recvDn;
    logic [10:0] o_byte_len;
    logic        o_rx_err;
    logic        o_fcs_err;

    rx_word_packer #(.MAX_WORDS(MAX_WORDS), .MIN_PREAMBLE(1)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_rxd        (i_rxd),
        .i_rx_dv      (i_rx_dv),
        .i_rx_er      (i_rx_er),
        .o_rx_data    (o_rx_data),
        .o_wordNum    (o_wordNum),
        .o_data_valid (o_data_valid),
        .o_recvDn     (o_recvDn),
        .o_byte_len   (o_byte_len),
        .o_rx_err     (o_rx_err),
        .o_fcs_err    (o_fcs_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        int          len;
        logic        err;
        logic        fcs;
        logic [9:0]  wnum;
        logic [15:0] wdata;
        logic        after_strobe;
    } done_t;

    int          checks = 0;
    int          errors = 0;
    logic [25:0] exp_words[$];
    done_t       exp_done[$];
    logic [7:0]  frm[$];
    logic        prev_dv;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Standard Ethernet CRC-32 (reflected form) over the first len bytes of frm.
    function automatic logic [31:0] eth_crc(input int len);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < len; i++) begin
            c = c ^ {24'h0, frm[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic append_fcs();
        logic [31:0] c;
        c = eth_crc(frm.size());
        frm.push_back(c[7:0]);
        frm.push_back(c[15:8]);
        frm.push_back(c[23:16]);
        frm.push_back(c[31:24]);
    endtask

    task automatic fill_random(input int n, input bit avoid55);
        logic [7:0] b;
        frm.delete();
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom_range(0, 255));
            if (avoid55 && b == 8'h55) b = 8'h56;
            frm.push_back(b);
        end
    endtask

    function automatic logic fcs_is_bad();
        int n;
        n = frm.size();
`ifdef RX_FCS_CHECK_EN
        if (n < 4) return 1'b1;
        return eth_crc(n - 4) != {frm[n-1], frm[n-2], frm[n-3], frm[n-4]};
`else
        return 1'b0;
`endif
    endfunction

    // Reference: words are byte pairs, odd tail padded, only the first MAX_WORDS emitted.
    task automatic model_frame(input int er_pos, input bit with_done);
        int          n, nw;
        logic [7:0]  hi, lo;
        logic [15:0] last;
        done_t       d;
        n    = frm.size();
        nw   = (n + 1) / 2;
        last = 16'h0000;
        for (int k = 0; k < nw && k < MAX_WORDS; k++) begin
            hi   = frm[2*k];
            lo   = (2*k + 1 < n) ? frm[2*k+1] : 8'h00;
            last = {hi, lo};
            exp_words.push_back({10'(k + 1), last});
        end
        if (with_done) begin
            d.fcs          = fcs_is_bad();
            d.len          = (n > 2047) ? 2047 : n;
            d.err          = (er_pos >= 0 && er_pos < n) || (nw > MAX_WORDS) || d.fcs;
            d.wnum         = 10'((nw > MAX_WORDS) ? MAX_WORDS : nw);
            d.wdata        = last;
            d.after_strobe = (n > 0) && (nw <= MAX_WORDS);
            exp_done.push_back(d);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic er);
        @(negedge i_clk);
        i_rx_dv = 1'b1;
        i_rxd   = b;
        i_rx_er = er;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge i_clk);
            i_rx_dv = 1'b0;
            i_rxd   = 8'h00;
            i_rx_er = 1'b0;
        end
    endtask

    task automatic run_frame(input int npre, input int er_pos, input int gap);
        model_frame(er_pos, 1'b1);
        for (int i = 0; i < npre; i++) send_byte(8'h55, 1'b0);
        send_byte(8'hD5, 1'b0);
        for (int i = 0; i < frm.size(); i++) send_byte(frm[i], i == er_pos);
        idle(gap);
    endtask

    initial begin
        prev_dv = 1'b0;
        forever begin
            @(posedge i_clk);
            #1;
            if (i_rst) begin
                prev_dv = 1'b0;
            end else begin
                if (o_data_valid || o_recvDn)
                    check("strobe_exclusive", 64'(o_data_valid & o_recvDn), 64'd0);
                if (o_data_valid) begin
                    if (exp_words.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_strobe: got word %0d data %0h expected none", o_wordNum, o_rx_data);
                    end else begin
                        logic [25:0] e;
                        e = exp_words.pop_front();
                        check("word_num", 64'(o_wordNum), 64'(e[25:16]));
                        check("word_data", 64'(o_rx_data), 64'(e[15:0]));
                    end
                end
                if (o_recvDn) begin
                    if (exp_done.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got len %0d expected no done", o_byte_len);
                    end else begin
                        done_t d;
                        d = exp_done.pop_front();
                        check("done_byte_len", 64'(o_byte_len), 64'(d.len));
                        check("done_rx_err", 64'(o_rx_err), 64'(d.err));
                        check("done_fcs_err", 64'(o_fcs_err), 64'(d.fcs));
                        check("done_wordnum", 64'(o_wordNum), 64'(d.wnum));
                        check("done_rx_data", 64'(o_rx_data), 64'(d.wdata));
                        if (d.after_strobe) check("done_after_strobe", 64'(prev_dv), 64'd1);
                    end
                end
                prev_dv = o_data_valid;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, er;
        i_rst   = 1'b0;
        i_rxd   = 8'h00;
        i_rx_dv = 1'b0;
        i_rx_er = 1'b0;
        #2 i_rst = 1'b1;
        #1;
        check("rst_rx_data", 64'(o_rx_data), 64'd0);
        check("rst_strobes", 64'({o_data_valid, o_recvDn}), 64'd0);
        check("rst_status", 64'({o_wordNum, o_byte_len, o_rx_err, o_fcs_err}), 64'd0);
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        idle(3);

        // 64-byte frame starting 01 00 5E 00 01 81, valid FCS, 7-byte preamble
        fill_random(60, 1'b0);
        frm[0] = 8'h01; frm[1] = 8'h00; frm[2] = 8'h5E;
        frm[3] = 8'h00; frm[4] = 8'h01; frm[5] = 8'h81;
        append_fcs();
        run_frame(7, -1, 8);
        check("hold_byte_len", 64'(o_byte_len), 64'd64);
        check("hold_wordnum", 64'(o_wordNum), 64'd32);
        check("hold_rx_err", 64'(o_rx_err), 64'd0);

        // 61-byte frame: odd tail
        fill_random(57, 1'b0);
        append_fcs();
        run_frame(7, -1, 6);

        // rx_er on byte 20
        fill_random(60, 1'b0);
        append_fcs();
        run_frame(7, 19, 6);

        // zero-byte frame
        frm.delete();
        run_frame(3, -1, 6);

        // bad preamble -> drop, then a good frame
        send_byte(8'h55, 1'b0);
        send_byte(8'h55, 1'b0);
        send_byte(8'h5D, 1'b0);
        fill_random(12, 1'b0);
        for (int i = 0; i < 12; i++) send_byte(frm[i], 1'b0);
        idle(4);
        send_byte(8'hD5, 1'b0);
        send_byte(8'h11, 1'b0);
        idle(4);
        fill_random(20, 1'b0);
        append_fcs();
        run_frame(2, -1, 6);

        // truncation past MAX_WORDS
        fill_random(1596, 1'b0);
        append_fcs();
        run_frame(7, -1, 6);

        // reset after byte 30 of a frame; remainder must be dropped
        fill_random(64, 1'b0);
        for (int i = 0; i < 64; i++) if (frm[i] == 8'h55) frm[i] = 8'h56;
        for (int k = 0; k < 15; k++) exp_words.push_back({10'(k + 1), frm[2*k], frm[2*k+1]});
        for (int i = 0; i < 7; i++) send_byte(8'h55, 1'b0);
        send_byte(8'hD5, 1'b0);
        for (int i = 0; i < 30; i++) send_byte(frm[i], 1'b0);
        @(negedge i_clk);
        i_rst = 1'b1;
        i_rxd = frm[30];
        #1;
        check("midrst_rx_data", 64'(o_rx_data), 64'd0);
        check("midrst_status", 64'({o_wordNum, o_byte_len, o_rx_err, o_fcs_err, o_data_valid, o_recvDn}), 64'd0);
        @(negedge i_clk);
        i_rxd = frm[31];
        @(negedge i_clk);
        i_rst = 1'b0;
        i_rxd = frm[32];
        for (int i = 33; i < 64; i++) send_byte(frm[i], 1'b0);
        idle(5);
        fill_random(30, 1'b0);
        append_fcs();
        run_frame(7, -1, 6);

        // corrupted FCS bit
        fill_random(60, 1'b0);
        append_fcs();
        frm[63] = frm[63] ^ 8'h10;
        run_frame(7, -1, 6);

        // randomized frames, including occasional drops
        for (int t = 0; t < 20; t++) begin
            if ($urandom_range(0, 4) == 0) begin
                send_byte(8'hD5, 1'b0);
                send_byte(8'h55, 1'b0);
                send_byte(8'hD5, 1'b0);
                idle(4);
            end else begin
                n = $urandom_range(0, 90);
                if (n >= 4 && $urandom_range(0, 1) == 1) begin
                    fill_random(n - 4, 1'b0);
                    append_fcs();
                end else begin
                    fill_random(n, 1'b0);
                end
                er = (n > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
                run_frame($urandom_range(1, 12), er, $urandom_range(3, 8));
            end
        end

        idle(10);
        check("words_left", 64'(exp_words.size()), 64'd0);
        check("done_left", 64'(exp_done.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
